// File: rtl/div_iter_if.sv
// Handshake and operand bundle between the EX stage (master) and the iterative divider (slave).
interface div_iter_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips the loop and returns 0 in two edges.
module div_iter (
   input  logic      clk,
   input  logic      rst,
   div_iter_if.slave bus
);

`ifdef DIV_ZERO_SHORTCUT_EN
   typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;
`else
   typedef enum logic [1:0] {StFree, StOn, StEnd} state_e;
`endif

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] dividend_q, dividend_d;
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quot_q, quot_d;
   logic        sign1_q, sign1_d;
   logic        sign2_q, sign2_d;
   logic        signed_q, signed_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [31:0] abs1, abs2;
   logic [32:0] trial;
   logic [31:0] rem_step, quot_step;
   logic [31:0] rem_fix, quot_fix;

   always_comb begin
      abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
      abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

      // Dividend register shifts left so its MSB is always the next bit to bring down.
      trial = {rem_q, dividend_q[31]} - {1'b0, divisor_q};
      if (!trial[32]) begin
         rem_step  = trial[31:0];
         quot_step = {quot_q[30:0], 1'b1};
      end else begin
         rem_step  = {rem_q[30:0], dividend_q[31]};
         quot_step = {quot_q[30:0], 1'b0};
      end

      quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~quot_step + 32'd1) : quot_step;
      rem_fix  = (signed_q && sign1_q) ? (~rem_step + 32'd1) : rem_step;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      sign1_d    = sign1_q;
      sign2_d    = sign2_q;
      signed_d   = signed_q;
      result_d   = result_q;
      ready_d    = ready_q;

      unique case (state_q)
         StFree: begin
            if (bus.start_i && !bus.annul_i) begin
               dividend_d = abs1;
               divisor_d  = abs2;
               sign1_d    = bus.opdata1_i[31];
               sign2_d    = bus.opdata2_i[31];
               signed_d   = bus.signed_div_i;
               cnt_d      = 5'd0;
               rem_d      = 32'd0;
               quot_d     = 32'd0;
`ifdef DIV_ZERO_SHORTCUT_EN
               state_d    = (bus.opdata2_i == 32'd0) ? StByZero : StOn;
`else
               state_d    = StOn;
`endif
            end
         end
`ifdef DIV_ZERO_SHORTCUT_EN
         StByZero: begin
            result_d = 64'd0;
            ready_d  = 1'b1;
            state_d  = StEnd;
         end
`endif
         StOn: begin
            if (bus.annul_i) begin
               cnt_d    = 5'd0;
               result_d = 64'd0;
               ready_d  = 1'b0;
               state_d  = StFree;
            end else begin
               rem_d      = rem_step;
               quot_d     = quot_step;
               dividend_d = {dividend_q[30:0], 1'b0};
               cnt_d      = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  result_d = {rem_fix, quot_fix};
                  ready_d  = 1'b1;
                  state_d  = StEnd;
               end
            end
         end
         StEnd: begin
            if (!bus.start_i) begin
               result_d = 64'd0;
               ready_d  = 1'b0;
               state_d  = StFree;
            end
         end
         default: state_d = StFree;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StFree;
         cnt_q      <= 5'd0;
         dividend_q <= 32'd0;
         divisor_q  <= 32'd0;
         rem_q      <= 32'd0;
         quot_q     <= 32'd0;
         sign1_q    <= 1'b0;
         sign2_q    <= 1'b0;
         signed_q   <= 1'b0;
         result_q   <= 64'd0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         sign1_q    <= sign1_d;
         sign2_q    <= sign2_d;
         signed_q   <= signed_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected {rem, quot} and latency queued at issue, popped on ready.
module tb_div_iter;
   logic clk = 1'b0;
   logic rst;

   div_iter_if bus ();

   div_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

`ifdef DIV_ZERO_SHORTCUT_EN
   localparam int ZeroLat = 2;
`else
   localparam int ZeroLat = 33;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];
   int          lat_q[$];

   function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      if (mb == 32'd0) begin
`ifdef DIV_ZERO_SHORTCUT_EN
         return 64'd0;
`else
         q = 32'hFFFF_FFFF;
         r = ma;
`endif
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
      if (s && (a[31] ^ b[31])) q = -q;
      if (s && a[31]) r = -r;
      return {r, q};
   endfunction

   // Call just after a posedge; the following edge samples the request.
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
      bus.signed_div_i = s;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      exp_q.push_back(exp);
      lat_q.push_back(lat);
   endtask

   task automatic wait_ready(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready_o === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic drop_start();
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start_i = 1'b1;
      bus.annul_i = 1'b0;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      #22;
      n_tests++;
      if (bus.ready_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready got %b want 0", bus.ready_o);
      end
      n_tests++;
      if (bus.result_o !== 64'd0) begin
         n_fail++; $display("FAIL reset_result got %h want 0", bus.result_o);
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_divu();
      int cyc, el;
      logic [63:0] ex;
      issue(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
      wait_ready(cyc);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (cyc !== el) begin n_fail++; $display("FAIL divu_lat got %0d want %0d", cyc, el); end
      n_tests++;
      if (bus.result_o !== ex) begin
         n_fail++; $display("FAIL divu_result got %h want %h", bus.result_o, ex);
      end
      // ready/result must hold while start stays high, even with annul and new operands.
      bus.annul_i = 1'b1;
      bus.opdata1_i = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      bus.annul_i = 1'b0;
      n_tests++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== ex) begin
         n_fail++; $display("FAIL end_hold got %b/%h want 1/%h", bus.ready_o, bus.result_o, ex);
      end
      drop_start();
      n_tests++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
         n_fail++; $display("FAIL end_clear got %b/%h want 0/0", bus.ready_o, bus.result_o);
      end
      issue(1'b0, 32'hFFFF_FFF9, 32'd2, {32'h1, 32'h7FFF_FFFC}, 33);
      wait_ready(cyc);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (cyc !== el || bus.result_o !== ex) begin
         n_fail++; $display("FAIL divu_big got %0d/%h want %0d/%h", cyc, bus.result_o, el, ex);
      end
      drop_start();
   endtask

   task automatic test_signed();
      int cyc, el;
      logic [63:0] ex;
      logic [31:0] a_tab[3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
      logic [31:0] b_tab[3] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      logic [63:0] r_tab[3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000},
                                {32'h1, 32'hFFFF_FFFD}};
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, a_tab[i], b_tab[i], r_tab[i], 33);
         wait_ready(cyc);
         ex = exp_q.pop_front(); el = lat_q.pop_front();
         n_tests++;
         if (cyc !== el || bus.result_o !== ex) begin
            n_fail++;
            $display("FAIL signed_%0d got %0d/%h want %0d/%h", i, cyc, bus.result_o, el, ex);
         end
         drop_start();
      end
   endtask

   task automatic test_div_zero();
      int cyc, el;
      logic [63:0] ex;
`ifdef DIV_ZERO_SHORTCUT_EN
      issue(1'b0, 32'd5, 32'd0, 64'd0, ZeroLat);
`else
      issue(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZeroLat);
`endif
      wait_ready(cyc);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (cyc !== el || bus.result_o !== ex) begin
         n_fail++; $display("FAIL div_zero got %0d/%h want %0d/%h", cyc, bus.result_o, el, ex);
      end
      drop_start();
   endtask

   task automatic test_annul();
      int cyc, el, highs;
      logic [63:0] ex;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i = 1'b1;
      repeat (11) @(posedge clk);   // E0 plus steps 0..9
      #1;
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      bus.annul_i = 1'b0;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) highs++;
         @(posedge clk);
         #1;
      end
      n_tests++;
      if (highs !== 0) begin n_fail++; $display("FAIL annul_quiet got %0d want 0", highs); end
      issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
      wait_ready(cyc);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (cyc !== el || bus.result_o !== ex) begin
         n_fail++; $display("FAIL after_annul got %0d/%h want %0d/%h", cyc, bus.result_o, el, ex);
      end
      drop_start();
   endtask

   task automatic test_async_reset();
      int cyc, el;
      logic [63:0] ex;
      // Reset mid-ON with start still held: a fresh full-length run must follow.
      issue(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
         n_fail++; $display("FAIL rst_on got %b/%h want 0/0", bus.ready_o, bus.result_o);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_ready(cyc);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (cyc !== el || bus.result_o !== ex) begin
         n_fail++; $display("FAIL rst_rerun got %0d/%h want %0d/%h", cyc, bus.result_o, el, ex);
      end
      // Reset in END between edges must clear the outputs without waiting for a clock.
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
         n_fail++; $display("FAIL rst_async got %b/%h want 0/0", bus.ready_o, bus.result_o);
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int cyc, el;
      logic [63:0] ex;
      logic s;
      logic [31:0] a, b;
      for (int i = 0; i < 14; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom();
         b = (i % 5 == 4) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300)));
         if (i == 0) a = 32'h8000_0000;
         if (i == 1) b = 32'd1;
         issue(s, a, b, model(s, a, b), (b == 32'd0) ? ZeroLat : 33);
         wait_ready(cyc);
         ex = exp_q.pop_front(); el = lat_q.pop_front();
         n_tests++;
         if (cyc !== el || bus.result_o !== ex) begin
            n_fail++;
            $display("FAIL b2b_%0d s=%b a=%h b=%h got %0d/%h want %0d/%h", i, s, a, b, cyc,
                     bus.result_o, el, ex);
         end
         drop_start();
      end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_signed();
      test_div_zero();
      test_annul();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
